// File: rtl/input_conditioner.sv
// Input conditioner: 2-flop synchronizers plus independent debounce channels
// for a push-button and a 4-bit select bus, with registered change pulses.
// Optional feature: define INPUT_COND_RELEASE_PULSE_EN to enable btn_release;
// otherwise btn_release is tied to 0.

// One debounce channel: IDLE/COUNT FSM with its own counter and candidate.
module debounce_channel #(
  parameter int W               = 1,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] sync,
  output logic [W-1:0] stable
);
  typedef enum logic {IDLE, COUNT} state_t;

  // Extra bit so the compare against the target never wraps.
  localparam logic [CNT_W:0] TARGET     = (CNT_W+1)'(DEBOUNCE_CYCLES);
  // With a one-cycle requirement the first differing sync cycle is enough.
  localparam bit             ACCEPT_NOW = (DEBOUNCE_CYCLES <= 1);

  state_t         state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [W-1:0]   cand, cand_n, stable_n;
  logic [CNT_W:0] cnt_inc;

  assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);

  // State, counter, candidate and stable value registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      cand   <= '0;
      stable <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      cand   <= cand_n;
      stable <= stable_n;
    end
  end

  // Next-state logic: count consecutive matching cycles, accept on target.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cand_n   = cand;
    stable_n = stable;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (sync != stable) begin
          if (ACCEPT_NOW) begin
            stable_n = sync;
          end else begin
            cand_n  = sync;
            cnt_n   = CNT_W'(1);
            state_n = COUNT;
          end
        end
      end
      COUNT: begin
        if (sync == cand) begin
          if (cnt_inc >= TARGET) begin
            stable_n = cand;
            cnt_n    = '0;
            state_n  = IDLE;
          end else begin
            cnt_n = cnt_inc[CNT_W-1:0];
          end
        end else if (sync == stable) begin
          // Bounced back to the accepted value: drop the attempt.
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          // A third value (multi-bit bus only): restart on it.
          cand_n = sync;
          cnt_n  = CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  input  logic [3:0] select_in,
  output logic [3:0] select_out,
  output logic       select_changed,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release
);
  logic       btn_meta, sync_btn;
  logic [3:0] sel_meta, sync_sel;
  logic       btn_stable;
  logic [3:0] sel_stable;

  // Two-flop synchronizers on every raw input bit.
  always_ff @(posedge clock) begin
    if (!reset) begin
      btn_meta <= 1'b0;
      sync_btn <= 1'b0;
      sel_meta <= '0;
      sync_sel <= '0;
    end else begin
      btn_meta <= btn_in;
      sync_btn <= btn_meta;
      sel_meta <= select_in;
      sync_sel <= sel_meta;
    end
  end

  debounce_channel #(.W(1), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_btn (
    .clock  (clock),
    .reset  (reset),
    .sync   (sync_btn),
    .stable (btn_stable)
  );

  debounce_channel #(.W(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_sel (
    .clock  (clock),
    .reset  (reset),
    .sync   (sync_sel),
    .stable (sel_stable)
  );

  // Output stage: levels and their edge pulses leave together, one cycle
  // after acceptance, so each pulse lines up with the new visible value.
  always_ff @(posedge clock) begin
    if (!reset) begin
      select_out     <= '0;
      select_changed <= 1'b0;
      btn_level      <= 1'b0;
      btn_press      <= 1'b0;
    end else begin
      select_out     <= sel_stable;
      select_changed <= (sel_stable != select_out);
      btn_level      <= btn_stable;
      btn_press      <= btn_stable & ~btn_level;
    end
  end

`ifdef INPUT_COND_RELEASE_PULSE_EN
  // Falling-edge pulse of the debounced button.
  always_ff @(posedge clock) begin
    if (!reset) btn_release <= 1'b0;
    else        btn_release <= ~btn_stable & btn_level;
  end
`else
  assign btn_release = 1'b0;
`endif
endmodule

// File: tb/tb_input_conditioner.sv
// Scoreboard bench for input_conditioner with DEBOUNCE_CYCLES = 4.
// Stimulus pushes expected pulse events (cycle + value); a negedge monitor
// pops and compares whenever a pulse appears.
module tb_input_conditioner;
  localparam int D   = 4;
  localparam int LAT = 3 + D; // drive at negedge c -> visible at negedge c+1+2+D

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       btn_in = 1'b0;
  logic [3:0] select_in = 4'h0;
  logic [3:0] select_out;
  logic       select_changed, btn_level, btn_press, btn_release;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_t sel_q[$];
  exp_t press_q[$];
  exp_t rel_q[$];

  input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_in         (btn_in),
    .select_in      (select_in),
    .select_out     (select_out),
    .select_changed (select_changed),
    .btn_level      (btn_level),
    .btn_press      (btn_press),
    .btn_release    (btn_release)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every pulse must match the oldest expected event of its kind.
  always @(negedge clock) begin
    exp_t e;
    if (select_changed === 1'b1) begin
      if (sel_q.size() == 0) chk("sel_unexpected_pulse", 1, 0);
      else begin
        e = sel_q.pop_front();
        chk("sel_pulse_cycle", cyc, e.cyc);
        chk("sel_pulse_value", int'(select_out), int'(e.val));
      end
    end
    if (btn_press === 1'b1) begin
      if (press_q.size() == 0) chk("press_unexpected_pulse", 1, 0);
      else begin
        e = press_q.pop_front();
        chk("press_pulse_cycle", cyc, e.cyc);
        chk("press_level", int'(btn_level), 1);
      end
    end
    if (btn_release === 1'b1) begin
      if (rel_q.size() == 0) chk("release_unexpected_pulse", 1, 0);
      else begin
        e = rel_q.pop_front();
        chk("release_pulse_cycle", cyc, e.cyc);
        chk("release_level", int'(btn_level), 0);
      end
    end
  end

  initial begin
    // Reset state.
    step(3);
    chk("rst_select_out", int'(select_out), 0);
    chk("rst_btn_level", int'(btn_level), 0);
    chk("rst_select_changed", int'(select_changed), 0);
    chk("rst_btn_press", int'(btn_press), 0);
    chk("rst_btn_release", int'(btn_release), 0);
    reset = 1'b1;
    step(2);

    // Clean press: level and pulse 6 cycles after first sampling edge.
    btn_in = 1'b1;
    press_q.push_back('{cyc + LAT, 4'h1});
    step(LAT - 1);
    chk("press_not_early", int'(btn_level), 0);
    step(4);
    chk("press_level_held", int'(btn_level), 1);

    // Release after acceptance.
    btn_in = 1'b0;
`ifdef INPUT_COND_RELEASE_PULSE_EN
    rel_q.push_back('{cyc + LAT, 4'h0});
`endif
    step(10);
    chk("release_level_held", int'(btn_level), 0);

    // Bouncing button: alternate-cycle toggles never accepted.
    btn_in = 1'b1; step(1);
    btn_in = 1'b0; step(1);
    btn_in = 1'b1; step(1);
    btn_in = 1'b0; step(10);
    chk("bounce_level", int'(btn_level), 0);

    // Select 5 for two cycles then 9: goes straight 0 -> 9.
    select_in = 4'h5; step(2);
    select_in = 4'h9;
    sel_q.push_back('{cyc + LAT, 4'h9});
    step(LAT - 1);
    chk("sel9_not_early", int'(select_out), 0);
    step(5);
    chk("sel9_held", int'(select_out), 9);

    // Reset in the middle of counting select 3; button raised during reset.
    select_in = 4'h3; step(3);
    reset = 1'b0; btn_in = 1'b1; step(1);
    chk("midrst_select_out", int'(select_out), 0);
    chk("midrst_select_changed", int'(select_changed), 0);
    chk("midrst_btn_level", int'(btn_level), 0);
    reset = 1'b1;
    sel_q.push_back('{cyc + LAT, 4'h3});
    press_q.push_back('{cyc + LAT, 4'h1});
    step(LAT + 3);
    chk("after_rst_select_out", int'(select_out), 3);
    chk("after_rst_btn_level", int'(btn_level), 1);

    // Direct select change 3 -> 6 and final release.
    select_in = 4'h6;
    sel_q.push_back('{cyc + LAT, 4'h6});
    btn_in = 1'b0;
`ifdef INPUT_COND_RELEASE_PULSE_EN
    rel_q.push_back('{cyc + LAT, 4'h0});
`endif
    step(LAT + 4);
    chk("final_select_out", int'(select_out), 6);
    chk("final_btn_level", int'(btn_level), 0);

    // Every expected pulse must have been seen within its window.
    chk("sel_events_left", sel_q.size(), 0);
    chk("press_events_left", press_q.size(), 0);
    chk("release_events_left", rel_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000, setting the number of consecutive stable cycles required to accept a new input value (legal range 1..1048575).
REQ-002 The block SHALL have parameter CNT_W, default 20, setting the debounce counter width in bits.
REQ-003 The block SHALL have port clock, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-low (0 = reset).
REQ-005 The block SHALL have port btn_in, input, 1 bit: raw asynchronous push-button level.
REQ-006 The block SHALL have port select_in, input, 4 bits: raw asynchronous slide-switch bus, used as the register-select source.
REQ-007 The block SHALL have port select_out, output, 4 bits: debounced select value, driven to the display select input.
REQ-008 The block SHALL have port select_changed, output, 1 bit: one-cycle pulse when select_out updates.
REQ-009 The block SHALL have port btn_level, output, 1 bit: debounced button level.
REQ-010 The block SHALL have port btn_press, output, 1 bit: one-cycle pulse on a debounced 0->1 transition of btn_level.
REQ-011 The block SHALL have port btn_release, output, 1 bit: one-cycle pulse on a debounced 1->0 transition of btn_level (see Configuration).

Function
REQ-012 Each input bit SHALL pass through a 2-flop synchronizer before any other logic; the synchronized values are named sync_btn and sync_sel.
REQ-013 The button and the 4-bit select bus SHALL be separate debounce channels, each with its own CNT_W-bit counter, candidate register and 2-state FSM (IDLE, COUNT).
REQ-014 IDLE: sync value == stable output; counter held at 0; when sync != stable, the channel SHALL load the candidate with the sync value, set the counter to 1 and go to COUNT.
REQ-015 COUNT, sync == candidate: the counter SHALL increment; on the edge at which the counter would reach DEBOUNCE_CYCLES, the stable output SHALL load the candidate, the counter SHALL clear and the FSM SHALL return to IDLE.
REQ-016 COUNT, sync == stable (bounce back): the counter SHALL clear and the FSM SHALL return to IDLE with no output change.
REQ-017 COUNT, sync differs from both candidate and stable (select bus only): the candidate SHALL reload, the counter SHALL set to 1 and the FSM SHALL stay in COUNT.
REQ-018 Latency: a clean input change SHALL appear on select_out or btn_level exactly 2 + DEBOUNCE_CYCLES cycles after the first rising edge that samples it.
REQ-019 select_changed, btn_press and btn_release SHALL be registered, asserted for exactly one cycle, and aligned with the cycle in which the new stable value is first visible.
REQ-020 With DEBOUNCE_CYCLES == 1, any value held for one synchronized cycle SHALL be accepted.
REQ-021 The counter SHALL never wrap; it saturates logically by returning to 0 when accepted.

Reset
REQ-022 While reset == 0 at a rising edge, the block SHALL clear all synchronizer flops, counters and candidates, set both FSMs to IDLE, and drive select_out = 4'h0, btn_level = 0, and all pulses = 0.
REQ-023 Reset asserted mid-COUNT SHALL abort the count with no output update or pulse.
REQ-024 Inputs held nonzero through reset release SHALL be debounced normally after release and SHALL produce the corresponding pulses.

Configuration
REQ-025 With macro INPUT_COND_RELEASE_PULSE_EN defined, btn_release SHALL operate per REQ-011 and REQ-019.
REQ-026 Without INPUT_COND_RELEASE_PULSE_EN, btn_release SHALL be tied to constant 0 and its edge-detect logic SHALL be absent.

Verification (DEBOUNCE_CYCLES = 4)
REQ-027 Scenario: btn_in 0->1 held -> btn_level=1 and btn_press pulses 1 cycle, exactly 6 cycles after the first sampling edge.
REQ-028 Scenario: btn_in toggling 1,0,1,0 on alternate cycles, then steady 0 -> btn_level stays 0 and no pulses occur.
REQ-029 Scenario: select_in 0->5 for 2 cycles, then 9 held -> select_out goes directly 0->9 at 6 cycles after 9 is first sampled, with one select_changed pulse; 5 never appears.
REQ-030 Scenario: reset=0 for 1 cycle during COUNT of select_in=3 (select_in held at 3 afterwards) -> select_out=0 with no pulse, then select_out=3 at 6 cycles after reset release.
REQ-031 Scenario: button released after being accepted -> btn_release pulses once with the macro defined, and stays 0 without it.
